// File: rtl/remote_update_sequencer_if.sv
// Remote-update register port: address/data/strobes toward the block, status word back.
// Latency: none, pure wiring bundle.
// Backpressure: carried in-band by RU_STATUS busy and control-register fields.
interface remote_update_sequencer_if;
    logic [1:0]  RU_ADDR;
    logic [31:0] RU_DATA;
    logic        RU_CEb;
    logic        RU_WEb;
    logic [31:0] RU_STATUS;

    // Sequencer side drives the register port and reads status
    modport master (
        output RU_ADDR,
        output RU_DATA,
        output RU_CEb,
        output RU_WEb,
        input  RU_STATUS
    );

    // Remote-update block side
    modport slave (
        input  RU_ADDR,
        input  RU_DATA,
        input  RU_CEb,
        input  RU_WEb,
        output RU_STATUS
    );
endinterface

// File: rtl/remote_update_sequencer.sv
// Sequences remote-update register writes for reconfiguration (START) or image readback (READBACK).
// Latency: first write strobe one cycle after an accepted pulse; each step then waits for the block's ack.
// Backpressure: pulses outside IDLE are dropped; block busy stalls a step until TIMEOUT, then ERROR.
module remote_update_sequencer #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned SETTLE  = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       START,
    input  logic                       READBACK,
    input  logic [6:0]                 PGM,
    remote_update_sequencer_if.master  ru,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       ERROR,
    output logic [2:0]                 ERR_STEP,
    output logic [11:0]                RDBK_DATA
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DATA  = 3'd1,
        WR_CTRL  = 3'd2,
        WAIT_ACK = 3'd3,
        SETTLE_W = 3'd4,
        CAPTURE  = 3'd5,
        FINISH   = 3'd6
    } state_t;

    // Timeout compares against the 16-bit wait counter directly.
    localparam logic [15:0] TMO_LIMIT   = TIMEOUT[15:0];
    // SETTLE_W holds for SETTLE cycles: counter runs 0 .. SETTLE-1.
    localparam int unsigned SETTLE_M1   = (SETTLE > 0) ? (SETTLE - 1) : 0;
    localparam logic [15:0] SETTLE_LAST = SETTLE_M1[15:0];

    // Step indices: 0..2 parameter writes, 3 reconfigure trigger, 4 readback.
    localparam logic [2:0] STEP_RECONF = 3'd3;
    localparam logic [2:0] STEP_RDBK   = 3'd4;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [6:0]  pgm_q, pgm_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0] settle_cnt_q, settle_cnt_d;
    logic        busy_s1_q, busy_s_q;
    logic        ack;

    logic        ceb_d, web_d;
    logic [1:0]  addr_d;
    logic [31:0] data_d;
    logic        busy_d, done_d, error_d;
    logic [2:0]  err_step_d;
    logic [11:0] rdbk_d;

    // Status bits not consumed by the sequencer
    logic unused_status;
    assign unused_status = ^{ru.RU_STATUS[30:24], ru.RU_STATUS[15:12]};

    // Parameter index written in the data phase of each step
    function automatic logic [2:0] step_param(input logic [2:0] step);
        case (step)
            3'd0:    step_param = 3'd0;
            3'd1:    step_param = 3'd4;
            default: step_param = 3'd5;
        endcase
    endfunction

    // 12-bit parameter value for each step; readback writes zero data
    function automatic logic [11:0] step_wdata(input logic [2:0] step, input logic [6:0] pgm);
        case (step)
            3'd0:    step_wdata = 12'h004;
            3'd1:    step_wdata = {5'h00, pgm};
            3'd2:    step_wdata = 12'h001;
            default: step_wdata = 12'h000;
        endcase
    endfunction

    // Control-register command: write param, trigger reconfig, or read param
    function automatic logic [7:0] step_ctrl(input logic [2:0] step);
        case (step)
            STEP_RECONF: step_ctrl = 8'h80;
            STEP_RDBK:   step_ctrl = 8'h01;
            default:     step_ctrl = 8'h02;
        endcase
    endfunction

    // Two-flop synchroniser on the block's busy flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy_s1_q <= 1'b0;
            busy_s_q  <= 1'b0;
        end else begin
            busy_s1_q <= ru.RU_STATUS[31];
            busy_s_q  <= busy_s1_q;
        end
    end

    // The block has finished the last command once its control register clears and busy drops
    assign ack = (ru.RU_STATUS[23:16] == 8'h00) && !busy_s_q;

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, step bookkeeping and registered-output decode of the next state
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        pgm_d        = pgm_q;
        tmo_cnt_d    = tmo_cnt_q;
        settle_cnt_d = settle_cnt_q;
        error_d      = ERROR;
        err_step_d   = ERR_STEP;
        rdbk_d       = RDBK_DATA;

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d    = WR_DATA;
                    step_d     = 3'd0;
                    pgm_d      = PGM;
                    error_d    = 1'b0;
                    err_step_d = 3'd0;
                end else if (READBACK) begin
                    state_d    = WR_DATA;
                    step_d     = STEP_RDBK;
                    error_d    = 1'b0;
                    err_step_d = 3'd0;
                end
            end
            WR_DATA: begin
                state_d = WR_CTRL;
            end
            WR_CTRL: begin
                state_d   = WAIT_ACK;
                tmo_cnt_d = 16'd0;
            end
            WAIT_ACK: begin
                // First WAIT_ACK cycle is blind: status may not yet reflect the command just written
                if ((tmo_cnt_q != 16'd0) && ack) begin
                    tmo_cnt_d = 16'd0;
                    case (step_q)
                        3'd0, 3'd1: begin
                            step_d  = step_q + 3'd1;
                            state_d = WR_DATA;
                        end
                        3'd2: begin
                            // Reconfigure trigger has no data phase
                            step_d  = STEP_RECONF;
                            state_d = WR_CTRL;
                        end
                        STEP_RECONF: begin
                            state_d = FINISH;
                        end
                        default: begin
                            state_d      = SETTLE_W;
                            settle_cnt_d = 16'd0;
                        end
                    endcase
                end else if (tmo_cnt_q == TMO_LIMIT) begin
                    error_d    = 1'b1;
                    err_step_d = step_q;
                    state_d    = FINISH;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            SETTLE_W: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 16'd1;
                end
            end
            CAPTURE: begin
                rdbk_d  = ru.RU_STATUS[11:0];
                state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered
        ceb_d  = 1'b1;
        web_d  = 1'b1;
        addr_d = ru.RU_ADDR;
        data_d = ru.RU_DATA;
        case (state_d)
            WR_DATA: begin
                ceb_d  = 1'b0;
                web_d  = 1'b0;
                addr_d = 2'd0;
                data_d = {13'h0000, step_param(step_d), 4'h0, step_wdata(step_d, pgm_d)};
            end
            WR_CTRL: begin
                ceb_d  = 1'b0;
                web_d  = 1'b0;
                addr_d = 2'd1;
                data_d = {24'h000000, step_ctrl(step_d)};
            end
            default: begin
                ceb_d = 1'b1;
                web_d = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    // Step context, counters and all registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            step_q       <= 3'd0;
            pgm_q        <= 7'd0;
            tmo_cnt_q    <= 16'd0;
            settle_cnt_q <= 16'd0;
            ru.RU_CEb    <= 1'b1;
            ru.RU_WEb    <= 1'b1;
            ru.RU_ADDR   <= 2'd0;
            ru.RU_DATA   <= 32'd0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            ERROR        <= 1'b0;
            ERR_STEP     <= 3'd0;
            RDBK_DATA    <= 12'd0;
        end else begin
            step_q       <= step_d;
            pgm_q        <= pgm_d;
            tmo_cnt_q    <= tmo_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            ru.RU_CEb    <= ceb_d;
            ru.RU_WEb    <= web_d;
            ru.RU_ADDR   <= addr_d;
            ru.RU_DATA   <= data_d;
            BUSY         <= busy_d;
            DONE         <= done_d;
            ERROR        <= error_d;
            ERR_STEP     <= err_step_d;
            RDBK_DATA    <= rdbk_d;
        end
    end

endmodule

// File: tb/tb_remote_update_sequencer.sv
// Directed bench for remote_update_sequencer with a behavioural remote-update block model.
// Latency: model acks 5 cycles after each control write; readback data held on RU_STATUS[11:0].
// Backpressure: model can hold busy permanently to force the timeout path.
module tb_remote_update_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        READBACK = 1'b0;
    logic [6:0]  PGM = 7'h00;
    logic        BUSY, DONE, ERROR;
    logic [2:0]  ERR_STEP;
    logic [11:0] RDBK_DATA;

    int n_checks = 0;
    int n_errors = 0;

    // Block model state
    logic        m_busy = 1'b0;
    logic [7:0]  m_ctrl = 8'h00;
    logic [11:0] m_dout = 12'h000;
    logic        m_stuck = 1'b0;
    int          m_cnt = 0;

    // Write log and DONE counter
    logic [1:0]  log_addr [0:127];
    logic [31:0] log_data [0:127];
    int          wr_count = 0;
    int          done_count = 0;

    logic [1:0]  exp_addr [0:6];
    logic [31:0] exp_data [0:6];

    always #5 CLK = ~CLK;

    remote_update_sequencer_if ru_if ();

    assign ru_if.RU_STATUS = {m_busy | m_stuck, 7'h00, m_ctrl, 4'h0, m_dout};

    remote_update_sequencer #(.TIMEOUT(64), .SETTLE(16)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .READBACK  (READBACK),
        .PGM       (PGM),
        .ru        (ru_if),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERROR     (ERROR),
        .ERR_STEP  (ERR_STEP),
        .RDBK_DATA (RDBK_DATA)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Drive a one-cycle pulse; returns in the cycle after acceptance
    task automatic pulse(input logic s, input logic r, input logic [6:0] p);
        START = s;
        READBACK = r;
        PGM = p;
        tick(1);
        START = 1'b0;
        READBACK = 1'b0;
        PGM = 7'h7F;
    endtask

    task automatic wait_done(input string tag, input int start_cnt);
        int cyc;
        cyc = 0;
        while (done_count == start_cnt && cyc < 3000) begin
            tick(1);
            cyc++;
        end
        check_val(tag, 32'(done_count != start_cnt), 32'd1);
    endtask

    task automatic check_start_log(input string tag, input int base, input logic [6:0] pgm);
        exp_data[2] = 32'h00040000 | {25'h0, pgm};
        for (int i = 0; i < 7; i++) begin
            check_val({tag, "_addr"}, {30'h0, log_addr[base + i]}, {30'h0, exp_addr[i]});
            check_val({tag, "_data"}, log_data[base + i], exp_data[i]);
        end
    endtask

    // Block model, write logger and strobe pairing check, all sampled mid-cycle
    always @(negedge CLK) begin
        check_val("ceb_web_pair", {31'h0, ru_if.RU_CEb}, {31'h0, ru_if.RU_WEb});
        if (!ru_if.RU_CEb && !ru_if.RU_WEb) begin
            if (wr_count < 128) begin
                log_addr[wr_count] = ru_if.RU_ADDR;
                log_data[wr_count] = ru_if.RU_DATA;
            end
            wr_count++;
            if (ru_if.RU_ADDR == 2'd1) begin
                m_ctrl = ru_if.RU_DATA[7:0];
                m_busy = 1'b1;
                m_cnt  = 5;
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 1'b0;
                m_ctrl = 8'h00;
            end
        end
        if (DONE) done_count++;
    end

    initial begin
        int w0, d0, cyc;

        exp_addr[0] = 2'd0; exp_data[0] = 32'h00000004;
        exp_addr[1] = 2'd1; exp_data[1] = 32'h00000002;
        exp_addr[2] = 2'd0; exp_data[2] = 32'h00040030;
        exp_addr[3] = 2'd1; exp_data[3] = 32'h00000002;
        exp_addr[4] = 2'd0; exp_data[4] = 32'h00050001;
        exp_addr[5] = 2'd1; exp_data[5] = 32'h00000002;
        exp_addr[6] = 2'd1; exp_data[6] = 32'h00000080;

        // Reset values
        tick(3);
        check_val("rst_ceb",   {31'h0, ru_if.RU_CEb}, 32'd1);
        check_val("rst_web",   {31'h0, ru_if.RU_WEb}, 32'd1);
        check_val("rst_addr",  {30'h0, ru_if.RU_ADDR}, 32'd0);
        check_val("rst_data",  ru_if.RU_DATA, 32'd0);
        check_val("rst_busy",  {31'h0, BUSY}, 32'd0);
        check_val("rst_done",  {31'h0, DONE}, 32'd0);
        check_val("rst_error", {31'h0, ERROR}, 32'd0);
        check_val("rst_rdbk",  {20'h0, RDBK_DATA}, 32'd0);
        RESET = 1'b0;
        tick(2);

        // Full START sequence, with first-write timing
        w0 = wr_count; d0 = done_count;
        pulse(1'b1, 1'b0, 7'h30);
        check_val("t1_n1_ceb",  {31'h0, ru_if.RU_CEb}, 32'd0);
        check_val("t1_n1_addr", {30'h0, ru_if.RU_ADDR}, 32'd0);
        check_val("t1_n1_data", ru_if.RU_DATA, 32'h00000004);
        check_val("t1_n1_busy", {31'h0, BUSY}, 32'd1);
        tick(1);
        check_val("t1_n2_ceb",  {31'h0, ru_if.RU_CEb}, 32'd0);
        check_val("t1_n2_addr", {30'h0, ru_if.RU_ADDR}, 32'd1);
        check_val("t1_n2_data", ru_if.RU_DATA, 32'h00000002);
        tick(1);
        check_val("t1_n3_ceb",  {31'h0, ru_if.RU_CEb}, 32'd1);
        wait_done("t1_done_seen", d0);
        tick(3);
        check_val("t1_wr_count", 32'(wr_count - w0), 32'd7);
        check_val("t1_done_once", 32'(done_count - d0), 32'd1);
        check_val("t1_error", {31'h0, ERROR}, 32'd0);
        check_val("t1_busy_end", {31'h0, BUSY}, 32'd0);
        check_start_log("t1", w0, 7'h30);

        // READBACK returning 12'h001
        m_dout = 12'h001;
        w0 = wr_count; d0 = done_count;
        pulse(1'b0, 1'b1, 7'h00);
        check_val("rb1_busy", {31'h0, BUSY}, 32'd1);
        wait_done("rb1_done_seen", d0);
        check_val("rb1_rdbk", {20'h0, RDBK_DATA}, 32'h001);
        tick(3);
        check_val("rb1_wr_count", 32'(wr_count - w0), 32'd2);
        check_val("rb1_addr0", {30'h0, log_addr[w0]}, 32'd0);
        check_val("rb1_data0", log_data[w0], 32'h00050000);
        check_val("rb1_addr1", {30'h0, log_addr[w0 + 1]}, 32'd1);
        check_val("rb1_data1", log_data[w0 + 1], 32'h00000001);
        check_val("rb1_done_once", 32'(done_count - d0), 32'd1);

        // Second READBACK with a different image value
        m_dout = 12'h3C7;
        d0 = done_count;
        pulse(1'b0, 1'b1, 7'h00);
        wait_done("rb2_done_seen", d0);
        check_val("rb2_rdbk", {20'h0, RDBK_DATA}, 32'h3C7);
        tick(3);

        // Timeout at step 0 with busy stuck high
        m_stuck = 1'b1;
        w0 = wr_count; d0 = done_count;
        pulse(1'b1, 1'b0, 7'h11);
        wait_done("to_done_seen", d0);
        check_val("to_error", {31'h0, ERROR}, 32'd1);
        check_val("to_err_step", {29'h0, ERR_STEP}, 32'd0);
        check_val("to_rdbk_hold", {20'h0, RDBK_DATA}, 32'h3C7);
        tick(20);
        check_val("to_wr_count", 32'(wr_count - w0), 32'd2);
        check_val("to_done_once", 32'(done_count - d0), 32'd1);
        check_val("to_busy_end", {31'h0, BUSY}, 32'd0);
        m_stuck = 1'b0;
        tick(3);

        // START and READBACK together: START wins; READBACK during BUSY is ignored
        w0 = wr_count; d0 = done_count;
        pulse(1'b1, 1'b1, 7'h5A);
        check_val("t5_error_clr", {31'h0, ERROR}, 32'd0);
        check_val("t5_first_data", ru_if.RU_DATA, 32'h00000004);
        tick(4);
        pulse(1'b0, 1'b1, 7'h00);
        wait_done("t5_done_seen", d0);
        tick(5);
        check_val("t5_wr_count", 32'(wr_count - w0), 32'd7);
        check_val("t5_done_once", 32'(done_count - d0), 32'd1);
        check_start_log("t5", w0, 7'h5A);

        // RESET during step 2 WAIT_ACK
        w0 = wr_count;
        pulse(1'b1, 1'b0, 7'h22);
        cyc = 0;
        while (wr_count - w0 < 6 && cyc < 500) begin
            tick(1);
            cyc++;
        end
        check_val("t6_reach_step2", 32'(wr_count - w0), 32'd6);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        check_val("t6_ceb",     {31'h0, ru_if.RU_CEb}, 32'd1);
        check_val("t6_web",     {31'h0, ru_if.RU_WEb}, 32'd1);
        check_val("t6_addr",    {30'h0, ru_if.RU_ADDR}, 32'd0);
        check_val("t6_data",    ru_if.RU_DATA, 32'd0);
        check_val("t6_busy",    {31'h0, BUSY}, 32'd0);
        check_val("t6_done",    {31'h0, DONE}, 32'd0);
        check_val("t6_error",   {31'h0, ERROR}, 32'd0);
        check_val("t6_errstep", {29'h0, ERR_STEP}, 32'd0);
        check_val("t6_rdbk",    {20'h0, RDBK_DATA}, 32'd0);
        d0 = done_count;
        w0 = wr_count;
        tick(40);
        check_val("t6_no_write", 32'(wr_count - w0), 32'd0);
        check_val("t6_no_done",  32'(done_count - d0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/remote_update_sequencer.md
REMOTE_UPDATE_SEQUENCER -- requirements
Module: remote_update_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096, WAIT_ACK cycles allowed before error (max 65535).
REQ-002 SHALL have parameter SETTLE, default 16, cycles between read acknowledge and data capture.
REQ-003 CLK  in  1  single clock; all logic on rising edge.
REQ-004 RESET  in  1  reset, synchronous, active-high.
REQ-005 START  in  1  one-cycle pulse; run the full reconfiguration sequence.
REQ-006 READBACK  in  1  one-cycle pulse; read current image (param 5).
REQ-007 PGM  in  7  application image start page; sampled on accepted START.
REQ-008 RU_ADDR  out  2  register select toward the remote-update interface.
REQ-009 RU_DATA  out  32  write data toward the interface.
REQ-010 RU_CEb  out  1  chip enable, active-low.
REQ-011 RU_WEb  out  1  write enable, active-low.
REQ-012 RU_STATUS  in  32  interface read word: [31]=busy, [23:16]=control register, [11:0]=data out.
REQ-013 BUSY  out  1  sequence in progress.
REQ-014 DONE  out  1  one-cycle pulse at sequence end, success or error.
REQ-015 ERROR  out  1  sticky timeout flag; cleared by next accepted START/READBACK.
REQ-016 ERR_STEP  out  3  step index that timed out.
REQ-017 RDBK_DATA  out  12  captured RU_STATUS[11:0] from last successful READBACK.

Function
REQ-018 SHALL register all outputs; RU_CEb and RU_WEb SHALL be low together for exactly one cycle per write and high otherwise.
REQ-019 SHALL synchronise RU_STATUS[31] through two flops (busy_s) before use.
REQ-020 SHALL implement states IDLE, WR_DATA, WR_CTRL, WAIT_ACK, SETTLE_W, CAPTURE, FINISH.
REQ-021 In IDLE, START or READBACK SHALL be accepted; if both assert the same cycle, START wins; pulses outside IDLE SHALL be ignored.
REQ-022 START step list: 0 {param 0, data 12'h004}, 1 {param 4, data {5'h0,PGM}}, 2 {param 5, data 12'h001}, 3 reconfigure; READBACK step list: 4 {param 5, read}.
REQ-023 WR_DATA SHALL write RU_ADDR=0, RU_DATA={13'h0,param[2:0],4'h0,data[11:0]}; skipped for step 3.
REQ-024 WR_CTRL SHALL write RU_ADDR=1, RU_DATA[7:0]=8'h02 (steps 0-2), 8'h80 (step 3), 8'h01 (step 4), upper bits zero.
REQ-025 Accepted pulse in cycle N SHALL give WR_DATA strobe in cycle N+1 and WR_CTRL strobe in N+2 (step 3: WR_CTRL in N+1).
REQ-026 WAIT_ACK SHALL exit when RU_STATUS[23:16]==0 and busy_s==0, evaluated no earlier than 2 cycles after WR_CTRL.
REQ-027 WAIT_ACK timeout counter (16 bits) SHALL reload to 0 on entry; reaching TIMEOUT SHALL set ERROR, ERR_STEP=step, go to FINISH.
REQ-028 After ack, steps 0-2 SHALL advance to next step's WR_DATA; step 3 SHALL go to FINISH; step 4 SHALL go to SETTLE_W.
REQ-029 SETTLE_W SHALL count SETTLE cycles then CAPTURE loads RDBK_DATA<=RU_STATUS[11:0] in one cycle, then FINISH.
REQ-030 FINISH SHALL pulse DONE for one cycle, drop BUSY, return to IDLE; BUSY SHALL be high from cycle N+1 through FINISH.
REQ-031 On error RDBK_DATA SHALL hold its previous value.

Reset
REQ-032 RESET SHALL, on the next edge, force IDLE, RU_CEb=1, RU_WEb=1, RU_ADDR=0, RU_DATA=0, BUSY=0, DONE=0, ERROR=0, ERR_STEP=0, RDBK_DATA=0, counters and synchronisers 0.
REQ-033 RESET mid-sequence SHALL abort with no further write strobe and no DONE pulse.

Verification
REQ-034 START, PGM=7'h30, model acks after 5 cycles -> writes (0,0x00000004),(1,0x02),(0,0x00040030),(1,0x02),(0,0x00050001),(1,0x02),(1,0x80); DONE once, ERROR=0.
REQ-035 READBACK, model returns RU_STATUS[11:0]=12'h001 -> writes (0,0x00050000),(1,0x01); RDBK_DATA=12'h001 SETTLE+1 cycles after ack; DONE pulse.
REQ-036 START, model holds busy=1 forever, TIMEOUT=64 -> ERROR=1, ERR_STEP=0, DONE 1 pulse, no further writes.
REQ-037 START and READBACK same cycle -> START sequence only; READBACK pulse during BUSY -> ignored, write count unchanged.
REQ-038 RESET asserted during step 2 WAIT_ACK -> next cycle all outputs at reset values, no DONE, RU_CEb stays high.
